fifo_unpacker: RTL and testbench
================================

FIFO_UNPACKER -- requirements
Module: fifo_unpacker

Interface
REQ-001 SHALL have parameter WORD_WIDTH, default 32, FIFO word width in bits.
REQ-002 SHALL have parameter BYTE_WIDTH, default 8, output symbol width; WORD_WIDTH SHALL be an integer multiple of BYTE_WIDTH; LANES = WORD_WIDTH/BYTE_WIDTH.
REQ-003 SHALL have parameter LSB_FIRST, default 1: 1 = lane 0 (bits BYTE_WIDTH-1:0) emitted first; 0 = most-significant lane first.
REQ-004 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-005 SHALL have port sync_reset_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port en  input  1  permits new FIFO pops when high.
REQ-007 SHALL have port fifo_empty  input  1  upstream FIFO empty flag.
REQ-008 SHALL have port fifo_rd_data  input  WORD_WIDTH  upstream FIFO head word, combinationally valid whenever fifo_empty is low.
REQ-009 SHALL have port fifo_rd_en  output  1  one-cycle pop strobe to the FIFO.
REQ-010 SHALL have port out_data  output  BYTE_WIDTH  current output symbol.
REQ-011 SHALL have port out_valid  output  1  out_data valid.
REQ-012 SHALL have port out_ready  input  1  downstream accepts the symbol.
REQ-013 SHALL have port out_last  output  1  current symbol is the final lane of its word.
REQ-014 SHALL have port busy  output  1  a word is held (state SEND).
REQ-015 SHALL have port word_count  output  16  number of words popped, modulo 2^16.

Function
REQ-016 SHALL implement an FSM with two states: EMPTY (no word held) and SEND (word held in word_reg, lane counter lane in 0..LANES-1).
REQ-017 In EMPTY, fifo_rd_en SHALL equal en AND NOT fifo_empty, combinationally; on that edge word_reg <= fifo_rd_data, lane <= 0, state -> SEND.
REQ-018 In SEND, out_valid SHALL be 1; out_data SHALL be lane number lane (LSB_FIRST=1) or lane number LANES-1-lane (LSB_FIRST=0) of word_reg.
REQ-019 out_last SHALL be 1 iff state is SEND and lane = LANES-1.
REQ-020 A transfer SHALL occur on a rising edge with out_valid and out_ready both high; without a transfer, out_data, out_last and lane SHALL hold.
REQ-021 On a transfer with lane < LANES-1, lane SHALL increment by 1 and the FIFO SHALL NOT be popped.
REQ-022 On a transfer with lane = LANES-1 and en=1 and fifo_empty=0, fifo_rd_en SHALL be 1 in that cycle, the next word SHALL load into word_reg, lane <= 0, and state SHALL stay SEND (zero-bubble back-to-back words).
REQ-023 On a transfer with lane = LANES-1 and (en=0 or fifo_empty=1), lane <= 0 and state SHALL go to EMPTY.
REQ-024 fifo_rd_en SHALL never be asserted while fifo_empty=1 and SHALL never be high for two words without an intervening capture; it is 0 in every case not listed in REQ-017/REQ-022.
REQ-025 en=0 SHALL NOT interrupt a word in progress; all remaining lanes of the held word SHALL be emitted.
REQ-026 word_count SHALL increment by 1 on each edge where fifo_rd_en=1, wrapping 16'hFFFF -> 0.
REQ-027 busy SHALL equal (state = SEND); out_valid SHALL equal busy.
REQ-028 Latency: a word present at the FIFO head while in EMPTY SHALL produce its first symbol with out_valid=1 in the cycle after fifo_rd_en.

Reset
REQ-029 While sync_reset_n=0, state SHALL be EMPTY, lane=0, word_reg=0, word_count=0, independent of clk.
REQ-030 During and after reset, fifo_rd_en, out_valid, out_last, busy SHALL be 0 and out_data SHALL be 0.
REQ-031 Reset asserted mid-word SHALL discard the held word's remaining lanes; no symbol of it SHALL appear after reset release.
REQ-032 The first pop after reset release SHALL occur no earlier than the first rising edge with sync_reset_n=1.

Verification
REQ-033 FIFO holds 32'h44332211, out_ready=1, en=1, LSB_FIRST=1 -> one fifo_rd_en pulse; out_data 11,22,33,44 on four consecutive cycles; out_last only on 44; word_count=1; state EMPTY after.
REQ-034 FIFO holds 32'hAABBCCDD then 32'h01020304, out_ready=1 -> eight consecutive valid symbols DD,CC,BB,AA,04,03,02,01 with no bubble; second fifo_rd_en coincides with the AA transfer.
REQ-035 LSB_FIRST=0, word 32'h44332211, out_ready toggling 1,0,1,0... -> symbols 44,33,22,11 each held stable while out_ready=0; exactly one pop.
REQ-036 en dropped to 0 after the first symbol of 32'h44332211 with a second word queued -> remaining 22,33,44 emitted, then EMPTY with fifo_rd_en=0 until en=1.
REQ-037 sync_reset_n pulsed low after the second symbol of a word -> outputs 0 immediately, word_count=0, no remaining lanes emitted; next queued word starts at lane 0.
REQ-038 fifo_empty=1 for 100 cycles with en=1 -> fifo_rd_en never asserted, out_valid=0, word_count unchanged.

Source files
------------

// File: rtl/fifo_unpacker_if.sv
// Handshake bundle between an upstream word FIFO, the unpacker and a downstream symbol sink.
// The unpacker takes the master view; the FIFO/sink environment takes the slave view.
interface fifo_unpacker_if #(
  parameter int WORD_WIDTH = 32,
  parameter int BYTE_WIDTH = 8
);
  logic                  fifo_empty;
  logic [WORD_WIDTH-1:0] fifo_rd_data;
  logic                  fifo_rd_en;
  logic [BYTE_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_last;

  modport master (
    input  fifo_empty, fifo_rd_data, out_ready,
    output fifo_rd_en, out_data, out_valid, out_last
  );

  modport slave (
    output fifo_empty, fifo_rd_data, out_ready,
    input  fifo_rd_en, out_data, out_valid, out_last
  );
endinterface

// File: rtl/fifo_unpacker.sv
// Pops WORD_WIDTH words from a FIFO and streams them out as BYTE_WIDTH symbols,
// one lane per accepted transfer, with zero-bubble chaining of back-to-back words.
module fifo_unpacker #(
  parameter int WORD_WIDTH = 32,
  parameter int BYTE_WIDTH = 8,
  parameter bit LSB_FIRST  = 1'b1
) (
  input  logic                 clk,
  input  logic                 sync_reset_n,
  input  logic                 en,
  fifo_unpacker_if.master      bus,
  output logic                 busy,
  output logic [15:0]          word_count
);
  localparam int LANES  = WORD_WIDTH / BYTE_WIDTH;
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

  typedef enum logic {EMPTY, SEND} state_t;

  state_t                state;
  logic [WORD_WIDTH-1:0] word_reg;
  logic [LANE_W-1:0]     lane;
  logic [LANE_W-1:0]     lane_next;
  logic [BYTE_WIDTH-1:0] out_data_q;
  logic                  out_last_q;
  logic                  xfer;
  logic                  at_last;
  logic                  pop;

  // Emission order is fixed here: transmit slot l maps to physical lane l or its mirror.
  function automatic logic [BYTE_WIDTH-1:0] pick(input logic [WORD_WIDTH-1:0] w,
                                                 input logic [LANE_W-1:0]     l);
    int idx;
    idx = LSB_FIRST ? int'(l) : (LANES - 1 - int'(l));
    return w[idx*BYTE_WIDTH +: BYTE_WIDTH];
  endfunction

  // NOTE: the pop strobe must be combinational so the FIFO head is captured on the
  // same edge it is popped; every term is fully specified, so no latch can form.
  always_comb begin
    xfer      = (state == SEND) && bus.out_ready;
    at_last   = (lane == LAST_LANE);
    lane_next = lane + LANE_W'(1);
    pop       = sync_reset_n && en && !bus.fifo_empty &&
                ((state == EMPTY) || (xfer && at_last));
  end

  assign bus.fifo_rd_en = pop;
  assign bus.out_data   = out_data_q;
  assign bus.out_last   = out_last_q;
  assign bus.out_valid  = (state == SEND);
  assign busy           = (state == SEND);

  // NOTE: all state uses non-blocking assignments so every register samples the
  // pre-edge values; the held word is reset too so nothing stale can leak out.
  always_ff @(posedge clk or negedge sync_reset_n) begin
    if (!sync_reset_n) begin
      state      <= EMPTY;
      word_reg   <= '0;
      lane       <= '0;
      out_data_q <= '0;
      out_last_q <= 1'b0;
      word_count <= '0;
    end else begin
      if (pop) word_count <= word_count + 16'd1;

      case (state)
        EMPTY: begin
          if (pop) begin
            state      <= SEND;
            word_reg   <= bus.fifo_rd_data;
            lane       <= '0;
            out_data_q <= pick(bus.fifo_rd_data, '0);
            out_last_q <= (LANES == 1);
          end
        end

        SEND: begin
          if (xfer) begin
            if (!at_last) begin
              lane       <= lane_next;
              out_data_q <= pick(word_reg, lane_next);
              out_last_q <= (lane_next == LAST_LANE);
            end else if (pop) begin
              // Chain straight into the next word without an idle cycle.
              word_reg   <= bus.fifo_rd_data;
              lane       <= '0;
              out_data_q <= pick(bus.fifo_rd_data, '0);
              out_last_q <= (LANES == 1);
            end else begin
              state      <= EMPTY;
              lane       <= '0;
              out_data_q <= '0;
              out_last_q <= 1'b0;
            end
          end
        end

        default: state <= EMPTY;
      endcase
    end
  end
endmodule

// File: tb/tb_fifo_unpacker.sv
// Randomized and directed bench for fifo_unpacker; two instances (LSB-first and MSB-first)
// share one stimulus stream and are checked against a queue-based symbol-stream model.
module tb_fifo_unpacker;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        rdy;
  logic        fifo_empty;
  logic [31:0] fifo_rd_data;
  logic        busy_lo, busy_hi;
  logic [15:0] cnt_lo, cnt_hi;

  int total = 0;
  int bad   = 0;

  // Environment and reference model state
  logic [31:0] fifo_q[$];
  logic [7:0]  pend_lo[$];
  logic [7:0]  pend_hi[$];
  int          exp_count;
  bit          fresh;

  always #5 clk = ~clk;

  fifo_unpacker_if #(.WORD_WIDTH(32), .BYTE_WIDTH(8)) bus_lo ();
  fifo_unpacker_if #(.WORD_WIDTH(32), .BYTE_WIDTH(8)) bus_hi ();

  assign bus_lo.fifo_empty   = fifo_empty;
  assign bus_lo.fifo_rd_data = fifo_rd_data;
  assign bus_lo.out_ready    = rdy;
  assign bus_hi.fifo_empty   = fifo_empty;
  assign bus_hi.fifo_rd_data = fifo_rd_data;
  assign bus_hi.out_ready    = rdy;

  fifo_unpacker #(.WORD_WIDTH(32), .BYTE_WIDTH(8), .LSB_FIRST(1'b1)) u_lo (
    .clk(clk), .sync_reset_n(rst_n), .en(en), .bus(bus_lo),
    .busy(busy_lo), .word_count(cnt_lo)
  );

  fifo_unpacker #(.WORD_WIDTH(32), .BYTE_WIDTH(8), .LSB_FIRST(1'b0)) u_hi (
    .clk(clk), .sync_reset_n(rst_n), .en(en), .bus(bus_hi),
    .busy(busy_hi), .word_count(cnt_hi)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive_fifo();
    fifo_empty   = (fifo_q.size() == 0);
    fifo_rd_data = (fifo_q.size() == 0) ? 32'h0 : fifo_q[0];
  endtask

  // One clock: settle inputs, compare against the model, take the edge, advance the model.
  task automatic tick();
    bit          pv, exp_pop;
    logic [31:0] w;
    drive_fifo();
    #1;
    pv      = (pend_lo.size() > 0);
    exp_pop = rst_n && en && (fifo_q.size() > 0) &&
              (!pv || (rdy && pend_lo.size() == 1));

    check("rd_en_lo", 32'(bus_lo.fifo_rd_en), 32'(exp_pop));
    check("rd_en_hi", 32'(bus_hi.fifo_rd_en), 32'(exp_pop));
    check("valid_lo", 32'(bus_lo.out_valid),  32'(pv));
    check("valid_hi", 32'(bus_hi.out_valid),  32'(pv));
    check("busy_lo",  32'(busy_lo),           32'(pv));
    check("last_lo",  32'(bus_lo.out_last),   32'(pend_lo.size() == 1));
    check("last_hi",  32'(bus_hi.out_last),   32'(pend_hi.size() == 1));
    check("count_lo", 32'(cnt_lo),            32'(exp_count[15:0]));
    check("count_hi", 32'(cnt_hi),            32'(exp_count[15:0]));
    if (pv) begin
      check("data_lo", 32'(bus_lo.out_data), 32'(pend_lo[0]));
      check("data_hi", 32'(bus_hi.out_data), 32'(pend_hi[0]));
    end else if (fresh) begin
      check("data_lo_idle", 32'(bus_lo.out_data), 32'h0);
      check("data_hi_idle", 32'(bus_hi.out_data), 32'h0);
    end

    @(posedge clk);
    if (rst_n) begin
      if (pv && rdy) begin
        void'(pend_lo.pop_front());
        void'(pend_hi.pop_front());
      end
      if (exp_pop) begin
        w = fifo_q.pop_front();
        for (int i = 0; i < 4; i++) begin
          pend_lo.push_back(w[8*i +: 8]);
          pend_hi.push_back(w[8*(3-i) +: 8]);
        end
        exp_count++;
        fresh = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Async reset: outputs must clear within 1 ns, before any clock edge.
  task automatic reset_pulse(input int cycles);
    rst_n = 1'b0;
    pend_lo.delete();
    pend_hi.delete();
    exp_count = 0;
    fresh     = 1'b1;
    #1;
    check("rst_valid", 32'(bus_lo.out_valid), 32'h0);
    check("rst_rd_en", 32'(bus_lo.fifo_rd_en), 32'h0);
    check("rst_count", 32'(cnt_lo), 32'h0);
    check("rst_data",  32'(bus_lo.out_data), 32'h0);
    for (int i = 0; i < cycles; i++) tick();
    rst_n = 1'b1;
  endtask

  initial begin
    en = 1'b0; rdy = 1'b0; rst_n = 1'b1;
    exp_count = 0; fresh = 1'b1;
    drive_fifo();
    #1;

    // Reset with a word waiting and en high: nothing may pop
    fifo_q.push_back(32'h44332211);
    en = 1'b1; rdy = 1'b1;
    reset_pulse(3);

    // Single word, LSB/MSB ordering, then idle
    run(7);

    // Two back-to-back words with no bubble
    fifo_q.push_back(32'hAABBCCDD);
    fifo_q.push_back(32'h01020304);
    run(11);

    // Ready toggling: each symbol held while not accepted
    fifo_q.push_back(32'h44332211);
    for (int i = 0; i < 12; i++) begin
      rdy = (i % 2 == 1);
      tick();
    end
    rdy = 1'b1;
    run(2);

    // en dropped after the first symbol with a second word queued
    fifo_q.push_back(32'h44332211);
    fifo_q.push_back(32'h55667788);
    run(2);
    en = 1'b0;
    run(8);
    en = 1'b1;
    run(7);

    // Reset mid-word after two symbols; queued word restarts at lane 0
    fifo_q.push_back(32'hCAFEF00D);
    fifo_q.push_back(32'h0BADBEEF);
    run(3);
    reset_pulse(2);
    run(8);

    // Long empty stretch with en high
    run(100);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 2000; i++) begin
      en  = ($urandom_range(99) < 80);
      rdy = ($urandom_range(99) < 70);
      if (fifo_q.size() < 4 && $urandom_range(99) < 35) fifo_q.push_back($urandom);
      if ($urandom_range(999) < 5) reset_pulse($urandom_range(2, 1));
      else tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time bound so the run can never hang
  initial begin
    #500000;
    $display("FAIL timeout total=%0d", total);
    $fatal(1, "timeout");
  end
endmodule
